// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types and constants for the ECC key sequencer
//
// Purpose: sequencer state enum, mailbox register map and DONE register codes.
// Ports:   none (package).

package ecc_pkg;

   localparam int NUM_WORDS = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_KICK    = 3'd2,
      S_WAIT    = 3'd3,
      S_STORE   = 3'd4,
      S_DONE_WR = 3'd5,
      S_ACK     = 3'd6,
      S_CLR     = 3'd7
   } seq_state_t;

   localparam logic [4:0]  MSG_BASE   = 5'd0;
   localparam logic [4:0]  KEY_BASE   = 5'd8;
   localparam logic [4:0]  START_ADDR = 5'd30;
   localparam logic [4:0]  DONE_ADDR  = 5'd31;

   localparam logic [31:0] DONE_OK    = 32'h1;
   localparam logic [31:0] DONE_ERR   = 32'h3;

   // The host owns the register file port while idle and while it acknowledges DONE.
   function automatic logic host_owns_port(input seq_state_t s);
      return (s == S_IDLE) || (s == S_ACK);
   endfunction

endpackage

// File: rtl/ecc_key_sequencer_if.sv
// rtl/ecc_key_sequencer_if.sv - bus bundle between host, register file, ECC core and sequencer
//
// Purpose: groups the Avalon slave, register file port, ECC core handshake and status.
// Modports:
//   slave  - the sequencer: consumes host requests, rf read data, core results
//   master - the environment: host, register file and ECC core

interface ecc_key_sequencer_if;

   logic         avl_read;
   logic         avl_write;
   logic [4:0]   avl_addr;
   logic [31:0]  avl_writedata;
   logic [3:0]   avl_byteenable;
   logic [31:0]  avl_readdata;
   logic         avl_waitrequest;

   logic [4:0]   rf_addr;
   logic         rf_load;
   logic [31:0]  rf_wdata;
   logic [3:0]   rf_byte_en;
   logic [31:0]  rf_rdata;
   logic         start_bit;

   logic [255:0] core_msg;
   logic         core_start;
   logic         core_done;
   logic [255:0] core_key;

   logic         busy;

   modport slave (
      input  avl_read, avl_write, avl_addr, avl_writedata, avl_byteenable,
      output avl_readdata, avl_waitrequest,
      output rf_addr, rf_load, rf_wdata, rf_byte_en,
      input  rf_rdata, start_bit,
      output core_msg, core_start,
      input  core_done, core_key,
      output busy
   );

   modport master (
      output avl_read, avl_write, avl_addr, avl_writedata, avl_byteenable,
      input  avl_readdata, avl_waitrequest,
      input  rf_addr, rf_load, rf_wdata, rf_byte_en,
      output rf_rdata, start_bit,
      input  core_msg, core_start,
      output core_done, core_key,
      input  busy
   );

endinterface

// File: rtl/rf_port_mux.sv
// rtl/rf_port_mux.sv - combinational host/engine select for the register file port
//
// Purpose: routes the single register file port either straight through to the Avalon
//          host or to the sequencer engine; stalls host accesses while the engine owns it.
// Ports:
//   i_host_owns        1   host owns the port this cycle
//   i_avl_*                host request (read, write, addr, writedata, byteenable)
//   i_rf_rdata        32   register file combinational read data
//   i_eng_addr/load/wdata  engine-side request
//   o_rf_addr/load/wdata/byte_en   register file port
//   o_avl_readdata    32   host read data
//   o_avl_waitrequest  1   host stall

module rf_port_mux (
   input  logic        i_host_owns,
   input  logic        i_avl_read,
   input  logic        i_avl_write,
   input  logic [4:0]  i_avl_addr,
   input  logic [31:0] i_avl_writedata,
   input  logic [3:0]  i_avl_byteenable,
   input  logic [31:0] i_rf_rdata,
   input  logic [4:0]  i_eng_addr,
   input  logic        i_eng_load,
   input  logic [31:0] i_eng_wdata,
   output logic [4:0]  o_rf_addr,
   output logic        o_rf_load,
   output logic [31:0] o_rf_wdata,
   output logic [3:0]  o_rf_byte_en,
   output logic [31:0] o_avl_readdata,
   output logic        o_avl_waitrequest
);

   always_comb begin
      if (i_host_owns) begin
         o_rf_addr         = i_avl_addr;
         o_rf_load         = i_avl_write;
         o_rf_wdata        = i_avl_writedata;
         o_rf_byte_en      = i_avl_byteenable;
         o_avl_readdata    = i_rf_rdata;
         o_avl_waitrequest = 1'b0;
      end else begin
         o_rf_addr         = i_eng_addr;
         o_rf_load         = i_eng_load;
         o_rf_wdata        = i_eng_wdata;
         o_rf_byte_en      = 4'hF;
         o_avl_readdata    = 32'h0;
         // Held requests are stalled, never dropped; the host retries once it owns the port.
         o_avl_waitrequest = i_avl_read | i_avl_write;
      end
   end

endmodule

// File: rtl/ecc_key_sequencer.sv
// rtl/ecc_key_sequencer.sv - mailbox port arbiter and ECC point-multiply run sequencer
//
// Purpose: shares the register file port between host and engine. On START it reads
//          MSG_IN, pulses the core, waits (with timeout) for the key, writes KEY_OUT and
//          DONE, then waits for the host to drop START before clearing DONE.
// Ports:
//   Clk    1   system clock
//   Reset  1   asynchronous active-low reset
//   bus        ecc_key_sequencer_if.slave (Avalon, register file, core, busy)
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in WAIT before aborting with the error code

module ecc_key_sequencer
   import ecc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                 Clk,
   input  logic                 Reset,
   ecc_key_sequencer_if.slave   bus
);

   localparam int             TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]     CNT_LAST = 3'(NUM_WORDS - 1);

   seq_state_t     r_state;
   seq_state_t     w_next;
   logic [2:0]     r_cnt;
   logic [TW-1:0]  r_tmo;
   logic [255:0]   r_msg;
   logic [255:0]   r_key;
   logic           r_err;

   logic [4:0]     w_eng_addr;
   logic           w_eng_load;
   logic [31:0]    w_eng_wdata;
   logic           w_core_start;
   logic           w_host_req;
   logic           w_host_owns;
   logic           w_cnt_last;
   logic           w_tmo_last;
   logic [7:0]     w_word_lsb;

   assign w_host_req  = bus.avl_read | bus.avl_write;
   assign w_host_owns = host_owns_port(r_state);
   assign w_cnt_last  = (r_cnt == CNT_LAST);
   assign w_tmo_last  = (r_tmo == TMO_LAST);
   assign w_word_lsb  = {r_cnt, 5'b0};

   always_comb begin
      w_next       = r_state;
      w_eng_addr   = 5'd0;
      w_eng_load   = 1'b0;
      w_eng_wdata  = 32'h0;
      w_core_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Only start on a quiet cycle so a host access is never cut off mid-flight.
            if (bus.start_bit && !w_host_req) w_next = S_LOAD;
         end
         S_LOAD: begin
            w_eng_addr = MSG_BASE + {2'b0, r_cnt};
            if (w_cnt_last) w_next = S_KICK;
         end
         S_KICK: begin
            w_core_start = 1'b1;
            w_next       = S_WAIT;
         end
         S_WAIT: begin
            // core_done takes priority over the timeout in the same cycle.
            if (bus.core_done)   w_next = S_STORE;
            else if (w_tmo_last) w_next = S_DONE_WR;
         end
         S_STORE: begin
            w_eng_load  = 1'b1;
            w_eng_addr  = KEY_BASE + {2'b0, r_cnt};
            w_eng_wdata = r_key[w_word_lsb +: 32];
            if (w_cnt_last) w_next = S_DONE_WR;
         end
         S_DONE_WR: begin
            w_eng_load  = 1'b1;
            w_eng_addr  = DONE_ADDR;
            w_eng_wdata = r_err ? DONE_ERR : DONE_OK;
            w_next      = S_ACK;
         end
         S_ACK: begin
            if (!bus.start_bit) w_next = S_CLR;
         end
         S_CLR: begin
            w_eng_load  = 1'b1;
            w_eng_addr  = DONE_ADDR;
            w_eng_wdata = 32'h0;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_tmo   <= '0;
         r_msg   <= '0;
         r_key   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_LOAD: begin
               r_msg[w_word_lsb +: 32] <= bus.rf_rdata;
               r_cnt <= w_cnt_last ? 3'd0 : r_cnt + 3'd1;
            end
            S_KICK: begin
               r_tmo <= '0;
               r_err <= 1'b0;
            end
            S_WAIT: begin
               r_tmo <= r_tmo + 1'b1;
               if (bus.core_done)   r_key <= bus.core_key;
               else if (w_tmo_last) r_err <= 1'b1;
            end
            S_STORE: begin
               r_cnt <= w_cnt_last ? 3'd0 : r_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   rf_port_mux u_mux (
      .i_host_owns       (w_host_owns),
      .i_avl_read        (bus.avl_read),
      .i_avl_write       (bus.avl_write),
      .i_avl_addr        (bus.avl_addr),
      .i_avl_writedata   (bus.avl_writedata),
      .i_avl_byteenable  (bus.avl_byteenable),
      .i_rf_rdata        (bus.rf_rdata),
      .i_eng_addr        (w_eng_addr),
      .i_eng_load        (w_eng_load),
      .i_eng_wdata       (w_eng_wdata),
      .o_rf_addr         (bus.rf_addr),
      .o_rf_load         (bus.rf_load),
      .o_rf_wdata        (bus.rf_wdata),
      .o_rf_byte_en      (bus.rf_byte_en),
      .o_avl_readdata    (bus.avl_readdata),
      .o_avl_waitrequest (bus.avl_waitrequest)
   );

   assign bus.core_msg   = r_msg;
   assign bus.core_start = w_core_start;
   assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ecc_key_sequencer.sv
// tb/tb_ecc_key_sequencer.sv - self-checking bench for ecc_key_sequencer

module tb_ecc_key_sequencer;

   localparam int TMO = 64;

   logic clk;
   logic rst_n;

   ecc_key_sequencer_if bus ();

   ecc_key_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: combinational read, byte-enabled write on the clock edge.
   logic [31:0] mem [32];
   assign bus.rf_rdata  = mem[bus.rf_addr];
   assign bus.start_bit = mem[30][0];

   always @(posedge clk) begin
      if (bus.rf_load)
         for (int b = 0; b < 4; b++)
            if (bus.rf_byte_en[b]) mem[bus.rf_addr][8*b +: 8] <= bus.rf_wdata[8*b +: 8];
   end

   // Core model: key = bitwise NOT of the operand, returned core_lat cycles after the kick.
   int   core_lat;
   logic core_en;
   int   cd;
   always @(negedge clk) begin
      bus.core_done = 1'b0;
      if (bus.core_start && core_en) cd = core_lat;
      else if (cd != 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            bus.core_done = 1'b1;
            bus.core_key  = ~bus.core_msg;
         end
      end
   end

   // Cycle-level monitor.
   int cyc;
   int n_kicks;
   int cyc_kick;
   int cyc_done;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.core_start) begin
            n_kicks++;
            cyc_kick = cyc;
         end
         if (bus.rf_load && bus.rf_addr == 5'd31 && bus.rf_wdata != 32'h0) cyc_done = cyc;
      end
   end

   int n_pass;
   int n_fail;
   int n_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic avl_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.avl_write = 1'b1; bus.avl_addr = a; bus.avl_writedata = d; bus.avl_byteenable = be;
      @(negedge clk);
      while (bus.avl_waitrequest && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) chk("wr_stall_bound", {31'b0, bus.avl_waitrequest}, 32'h0);
      @(posedge clk); #1;
      bus.avl_write = 1'b0;
   endtask

   task automatic avl_rd(input logic [4:0] a, output logic [31:0] d, output int stall);
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.avl_read = 1'b1; bus.avl_addr = a;
      @(negedge clk);
      while (bus.avl_waitrequest && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) chk("rd_stall_bound", {31'b0, bus.avl_waitrequest}, 32'h0);
      d = bus.avl_readdata;
      stall = n;
      @(posedge clk); #1;
      bus.avl_read = 1'b0;
   endtask

   logic [31:0] msg [8];

   function automatic logic [31:0] sentinel(input int i);
      return 32'hDEAD_0000 + i;
   endfunction

   task automatic prefill_keys();
      for (int i = 0; i < 8; i++) avl_wr(5'(8 + i), sentinel(i), 4'hF);
   endtask

   // Full host-driven run: load MSG_IN, start, read reg3 while the engine is busy,
   // poll DONE, check KEY_OUT and the handshake, then release START.
   task automatic do_run(input int lat, input logic en);
      logic [31:0] d;
      int st;
      int k0;
      core_en = en; core_lat = lat;
      for (int i = 0; i < 8; i++) avl_wr(5'(i), msg[i], 4'hF);
      k0 = n_kicks;
      avl_wr(5'd30, 32'h1, 4'hF);
      avl_rd(5'd3, d, st);
      chk("rd_reg3_during_busy", d, msg[3]);
      chk("rd_reg3_stalled", {31'b0, st > 0}, 32'h1);
      avl_rd(5'd31, d, st);
      chk("done_code", d, en ? 32'h1 : 32'h3);
      chk("kick_once", 32'(n_kicks - k0), 32'h1);
      // Success: core_done lands lat cycles after the kick, then 8 STORE + 1 DONE_WR.
      // Timeout: counter cleared in KICK, TMO WAIT cycles, then DONE_WR.
      chk("kick_to_done", 32'(cyc_done - cyc_kick), en ? 32'(lat + 9) : 32'(TMO + 1));
      for (int i = 0; i < 8; i++)
         chk($sformatf("key_word%0d", i), mem[8 + i], en ? ~msg[i] : sentinel(i));
      chk("busy_in_ack", {31'b0, bus.busy}, 32'h1);
      avl_wr(5'd30, 32'h0, 4'hF);
      @(posedge clk); @(posedge clk); #1;
      chk("done_cleared", mem[31], 32'h0);
      chk("busy_dropped", {31'b0, bus.busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] d;
      int st;
      int n;
      n_pass = 0; n_fail = 0; n_total = 0;
      cyc = 0; n_kicks = 0; cyc_kick = 0; cyc_done = 0; cd = 0;
      core_en = 1'b0; core_lat = 1;
      bus.avl_read = 1'b0; bus.avl_write = 1'b0; bus.avl_addr = 5'd0;
      bus.avl_writedata = 32'h0; bus.avl_byteenable = 4'h0;
      bus.core_done = 1'b0; bus.core_key = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      rst_n = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("rst_core_start", {31'b0, bus.core_start}, 32'h0);
      chk("rst_core_msg_lo", bus.core_msg[31:0], 32'h0);
      chk("rst_waitrequest", {31'b0, bus.avl_waitrequest}, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Byte-enable write in IDLE touches only byte 1.
      avl_wr(5'd5, 32'h1122_3344, 4'hF);
      avl_wr(5'd5, 32'hAABB_CCDD, 4'b0010);
      chk("be_mem", mem[5], 32'h1122_CC44);
      avl_rd(5'd5, d, st);
      chk("be_readback", d, 32'h1122_CC44);
      chk("be_no_stall", 32'(st), 32'h0);

      // Directed run with a 20-cycle core.
      for (int i = 0; i < 8; i++) msg[i] = 32'h1000_0000 + i;
      do_run(20, 1'b1);

      // Core never answers: timeout code, KEY_OUT untouched.
      prefill_keys();
      for (int i = 0; i < 8; i++) msg[i] = $urandom;
      do_run(1, 1'b0);

      // Randomized back-to-back runs.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) msg[i] = $urandom;
         do_run(int'($urandom_range(1, 40)), 1'b1);
      end

      // Reset during the fifth STORE cycle: only regs 8-11 written.
      prefill_keys();
      for (int i = 0; i < 8; i++) msg[i] = $urandom;
      core_en = 1'b1; core_lat = 10;
      for (int i = 0; i < 8; i++) avl_wr(5'(i), msg[i], 4'hF);
      avl_wr(5'd30, 32'h1, 4'hF);
      n = 0;
      @(negedge clk);
      while (!(bus.rf_load && bus.rf_addr == 5'd12) && n < 400) begin @(negedge clk); n++; end
      chk("store_reached", {27'b0, bus.rf_addr}, 32'd12);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, bus.busy}, 32'h0);
      chk("midrst_core_start", {31'b0, bus.core_start}, 32'h0);
      chk("midrst_rf_load", {31'b0, bus.rf_load}, 32'h0);
      avl_wr(5'd30, 32'h0, 4'hF);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", {31'b0, bus.busy}, 32'h0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("partial_key%0d", i), mem[8 + i], (i < 4) ? ~msg[i] : sentinel(i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
